// File: rtl/clk_period_meter.sv
// clk_period_meter: measures rise-to-rise period and rise-to-fall high time of a sampled signal in clock_in cycles.
// Optional macro CLK_PERIOD_METER_SYNC_EN inserts a 2-FF synchroniser ahead of the edge detector.
module clk_period_meter #(
    parameter int          WIDTH   = 32,
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             meas_valid,
    output logic [15:0]      meas_count,
    output logic             stalled
);
    typedef enum logic [1:0] {IDLE, MEAS_HI, MEAS_LO, STALL} state_t;

    localparam logic [WIDTH-1:0] CNT_MAX     = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_TIMEOUT = WIDTH'(TIMEOUT);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_sig_src;
    logic             r_sig;
    logic             r_sig_d;
    logic             w_rise;
    logic             w_fall;
    logic             w_timeout;
    logic             w_publish;
    logic             w_latch_hi;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] r_hi_latch;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_high;
    logic             r_valid;
    logic [15:0]      r_count;

`ifdef CLK_PERIOD_METER_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= sig_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sig_src = r_sync2;
`else
    assign w_sig_src = sig_in;
`endif

    // Sampling flops keep running while disabled so edges stay coherent on re-enable.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_sig   <= 1'b0;
            r_sig_d <= 1'b0;
        end else begin
            r_sig   <= w_sig_src;
            r_sig_d <= r_sig;
        end
    end

    assign w_rise    = r_sig & ~r_sig_d;
    assign w_fall    = ~r_sig & r_sig_d;
    assign w_timeout = (r_cnt == CNT_TIMEOUT);

    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_publish   = 1'b0;
        w_latch_hi  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise) w_state_nxt = MEAS_HI;
            end
            MEAS_HI: begin
                if (w_fall) begin
                    w_latch_hi  = 1'b1;
                    w_state_nxt = MEAS_LO;
                end else if (w_timeout) begin
                    w_state_nxt = STALL;
                end
            end
            MEAS_LO: begin
                if (w_rise) begin
                    w_publish   = 1'b1;
                    w_state_nxt = MEAS_HI;
                end else if (w_timeout) begin
                    w_state_nxt = STALL;
                end
            end
            STALL: begin
                // The period that ends a stall is incomplete, so it is never published.
                if (w_rise) w_state_nxt = MEAS_HI;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (!enable) begin
            w_state_nxt = IDLE;
            w_publish   = 1'b0;
            w_latch_hi  = 1'b0;
        end
    end

    always_comb begin
        w_cnt_nxt = '0;
        if (enable) begin
            if (w_rise) begin
                w_cnt_nxt = WIDTH'(1);
            end else if (r_state == MEAS_HI || r_state == MEAS_LO) begin
                w_cnt_nxt = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_cnt      <= '0;
            r_hi_latch <= '0;
            r_period   <= '0;
            r_high     <= '0;
            r_valid    <= 1'b0;
            r_count    <= '0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_valid <= w_publish;
            if (w_latch_hi) r_hi_latch <= r_cnt;
            if (w_publish) begin
                r_period <= r_cnt;
                r_high   <= r_hi_latch;
                r_count  <= r_count + 16'd1;
            end
        end
    end

    assign period     = r_period;
    assign high_time  = r_high;
    assign meas_valid = r_valid;
    assign meas_count = r_count;
    assign stalled    = (r_state == STALL);
endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench for clk_period_meter: fixed vector table, directed corner sequences and a
// randomized run, all against a timestamp-based reference model of the measurement rules.
module tb_clk_period_meter;
    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 20;
`ifdef CLK_PERIOD_METER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        clock_in = 1'b0;
    logic        reset    = 1'b1;
    logic        enable   = 1'b0;
    logic        sig_in   = 1'b0;
    logic [31:0] period;
    logic [31:0] high_time;
    logic        meas_valid;
    logic [15:0] meas_count;
    logic        stalled;

    clk_period_meter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clock_in  (clock_in),
        .reset     (reset),
        .enable    (enable),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .meas_valid(meas_valid),
        .meas_count(meas_count),
        .stalled   (stalled)
    );

    always #5 clock_in = ~clock_in;

    int    checks   = 0;
    int    failures = 0;
    string phase    = "init";

    // Reference model: sig_in history plus timestamps of the last accepted rise and fall.
    logic        hist[$];
    int          edge_n   = 0;
    bit          m_meas   = 0;
    bit          m_hfall  = 0;
    bit          m_stall  = 0;
    int          t_rise   = 0;
    int          t_fall   = 0;
    logic [31:0] e_period = 0;
    logic [31:0] e_high   = 0;
    logic        e_valid  = 0;
    logic [15:0] e_count  = 0;

    task automatic model_edge();
        logic r;
        logic d;
        edge_n++;
        if (reset) begin
            for (int i = 0; i < LAT + 2; i++) hist[i] = 1'b0;
            m_meas = 0; m_hfall = 0; m_stall = 0;
            e_period = 0; e_high = 0; e_valid = 0; e_count = 0;
            return;
        end
        r = hist[LAT];
        d = hist[LAT + 1];
        e_valid = 1'b0;
        if (!enable) begin
            m_meas  = 0;
            m_stall = 0;
        end else if (r && !d) begin
            if (m_meas && m_hfall) begin
                e_period = 32'(edge_n - t_rise);
                e_high   = 32'(t_fall - t_rise);
                e_valid  = 1'b1;
                e_count  = e_count + 16'd1;
            end
            m_meas = 1; m_hfall = 0; m_stall = 0; t_rise = edge_n;
        end else if (m_meas) begin
            if (!m_hfall && !r && d) begin
                m_hfall = 1;
                t_fall  = edge_n;
            end else if (edge_n - t_rise == TIMEOUT) begin
                m_meas  = 0;
                m_stall = 1;
            end
        end
        hist.push_front(sig_in);
        void'(hist.pop_back());
    endtask

    task automatic cmp_model();
        checks++;
        if ({period, high_time, meas_valid, meas_count, stalled} !==
            {e_period, e_high, e_valid, e_count, m_stall}) begin
            failures++;
            $display("FAIL model_%s edge=%0d got p=%0d h=%0d v=%0b c=%0d s=%0b exp p=%0d h=%0d v=%0b c=%0d s=%0b",
                     phase, edge_n, period, high_time, meas_valid, meas_count, stalled,
                     e_period, e_high, e_valid, e_count, m_stall);
        end
    endtask

    task automatic check_const(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic step(input logic en, input logic s, input logic rst);
        enable = en;
        sig_in = s;
        reset  = rst;
        model_edge();
        @(posedge clock_in);
        @(negedge clock_in);
        cmp_model();
    endtask

    task automatic run_pattern(input int hi, input int lo, input int reps);
        for (int r = 0; r < reps; r++) begin
            for (int k = 0; k < hi; k++) step(1'b1, 1'b1, 1'b0);
            for (int k = 0; k < lo; k++) step(1'b1, 1'b0, 1'b0);
        end
    endtask

    typedef struct {
        logic        sig;
        logic [31:0] period;
        logic [31:0] high;
        logic        valid;
        logic [15:0] count;
    } vec_t;

    vec_t tbl[20];
    vec_t zero_v;
    vec_t exp_v;

    initial begin
        tbl[0]  = '{1'b1, 32'd0, 32'd0, 1'b0, 16'd0};
        tbl[1]  = '{1'b1, 32'd0, 32'd0, 1'b0, 16'd0};
        tbl[2]  = '{1'b1, 32'd0, 32'd0, 1'b0, 16'd0};
        tbl[3]  = '{1'b0, 32'd0, 32'd0, 1'b0, 16'd0};
        tbl[4]  = '{1'b0, 32'd0, 32'd0, 1'b0, 16'd0};
        tbl[5]  = '{1'b1, 32'd0, 32'd0, 1'b0, 16'd0};
        tbl[6]  = '{1'b1, 32'd5, 32'd3, 1'b1, 16'd1};
        tbl[7]  = '{1'b1, 32'd5, 32'd3, 1'b0, 16'd1};
        tbl[8]  = '{1'b0, 32'd5, 32'd3, 1'b0, 16'd1};
        tbl[9]  = '{1'b0, 32'd5, 32'd3, 1'b0, 16'd1};
        tbl[10] = '{1'b1, 32'd5, 32'd3, 1'b0, 16'd1};
        tbl[11] = '{1'b1, 32'd5, 32'd3, 1'b1, 16'd2};
        tbl[12] = '{1'b1, 32'd5, 32'd3, 1'b0, 16'd2};
        tbl[13] = '{1'b0, 32'd5, 32'd3, 1'b0, 16'd2};
        tbl[14] = '{1'b0, 32'd5, 32'd3, 1'b0, 16'd2};
        tbl[15] = '{1'b1, 32'd5, 32'd3, 1'b0, 16'd2};
        tbl[16] = '{1'b1, 32'd5, 32'd3, 1'b1, 16'd3};
        tbl[17] = '{1'b1, 32'd5, 32'd3, 1'b0, 16'd3};
        tbl[18] = '{1'b0, 32'd5, 32'd3, 1'b0, 16'd3};
        tbl[19] = '{1'b0, 32'd5, 32'd3, 1'b0, 16'd3};
        zero_v  = '{1'b0, 32'd0, 32'd0, 1'b0, 16'd0};

        for (int i = 0; i < LAT + 2; i++) hist.push_back(1'b0);

        // Reset state
        phase = "reset";
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        check_const("reset_period", period, 32'd0);
        check_const("reset_high", high_time, 32'd0);
        check_const("reset_flags", {29'd0, meas_valid, stalled, 1'b0}, 32'd0);
        check_const("reset_count", {16'd0, meas_count}, 32'd0);

        // 3 high / 2 low vector table; outputs appear LAT cycles later with the synchroniser
        phase = "table";
        for (int i = 0; i < 20; i++) begin
            step(1'b1, tbl[i].sig, 1'b0);
            exp_v = (i >= LAT) ? tbl[i - LAT] : zero_v;
            checks++;
            if ({period, high_time, meas_valid, meas_count} !==
                {exp_v.period, exp_v.high, exp_v.valid, exp_v.count}) begin
                failures++;
                $display("FAIL table_row%0d got p=%0d h=%0d v=%0b c=%0d exp p=%0d h=%0d v=%0b c=%0d",
                         i, period, high_time, meas_valid, meas_count,
                         exp_v.period, exp_v.high, exp_v.valid, exp_v.count);
            end
        end
        check_const("table_count", {16'd0, meas_count}, 32'd3);

        // 1 high / 1 low toggling
        phase = "toggle";
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, (i % 2) == 0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
        check_const("toggle_period", period, 32'd2);
        check_const("toggle_high", high_time, 32'd1);
        check_const("toggle_count", {16'd0, meas_count}, 32'd9);

        // Stall with sig held high, then resume 3/2
        phase = "stall";
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 30; i++) step(1'b1, 1'b1, 1'b0);
        check_const("stall_flag", {31'd0, stalled}, 32'd1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        run_pattern(3, 2, 2);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        check_const("resume_stalled", {31'd0, stalled}, 32'd0);
        check_const("resume_period", period, 32'd5);
        check_const("resume_high", high_time, 32'd3);
        check_const("resume_count", {16'd0, meas_count}, 32'd2);

        // Enable dropped while low: holds values, next publish needs two rises
        phase = "enable";
        step(1'b1, 1'b0, 1'b1);
        run_pattern(3, 2, 3);
        run_pattern(3, 4, 1);
        check_const("pre_dis_count", {16'd0, meas_count}, 32'd3);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
        check_const("dis_stalled", {31'd0, stalled}, 32'd0);
        check_const("dis_period", period, 32'd5);
        check_const("dis_high", high_time, 32'd3);
        run_pattern(3, 2, 1);
        check_const("reen_first_rise_count", {16'd0, meas_count}, 32'd3);
        run_pattern(3, 2, 1);
        check_const("reen_second_rise_count", {16'd0, meas_count}, 32'd4);
        check_const("reen_period", period, 32'd5);

        // Reset pulse during MEAS_HI after three measurements
        phase = "midreset";
        step(1'b1, 1'b0, 1'b1);
        run_pattern(3, 2, 4);
        check_const("pre_reset_count", {16'd0, meas_count}, 32'd3);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        check_const("midreset_period", period, 32'd0);
        check_const("midreset_high", high_time, 32'd0);
        check_const("midreset_count", {16'd0, meas_count}, 32'd0);
        check_const("midreset_flags", {30'd0, meas_valid, stalled}, 32'd0);
        run_pattern(3, 2, 3);

        // Randomized segments with occasional stalls, enable drops and resets
        phase = "random";
        begin
            int cyc;
            int hi;
            int lo;
            cyc = 0;
            while (cyc < 1500) begin
                hi = ($urandom_range(0, 9) == 0) ? $urandom_range(18, 26) : $urandom_range(1, 6);
                lo = ($urandom_range(0, 9) == 0) ? $urandom_range(18, 26) : $urandom_range(1, 6);
                for (int k = 0; k < hi + lo; k++) begin
                    step(($urandom_range(0, 99) >= 3), (k < hi), ($urandom_range(0, 399) == 0));
                    cyc++;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
